// File: rtl/irq_ctrl.sv
// irq_ctrl: 8-source edge-triggered interrupt controller with a small
// register port (PENDING / MASK / STATUS / EOI) and a single-level
// request / acknowledge / end-of-interrupt handshake towards the CPU.
module irq_ctrl #(
  parameter int N_SRC = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] src,
  input  logic             cs,
  input  logic [3:0]       addr,
  input  logic [3:0]       we,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             irq,
  input  logic             iack,
  output logic [2:0]       irq_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SERV = 2'd2
  } state_t;

  localparam logic [1:0] REG_PENDING = 2'd0;
  localparam logic [1:0] REG_MASK    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_EOI     = 2'd3;

  state_t           state;
  state_t           state_nxt;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending;
  logic [N_SRC-1:0] mask;
  logic [2:0]       svc_id;

  logic [N_SRC-1:0] rise;
  logic             wr;
  logic             wr_pending;
  logic             wr_mask;
  logic             wr_eoi;
  logic             cand_vld;
  logic [2:0]       cand_id;
  logic             take_ack;
  logic             end_svc;
  logic [N_SRC-1:0] ack_clr;
  logic [N_SRC-1:0] w1c_clr;

  // Edge detection and register-port write decode (addr[1:0] ignored).
  assign rise       = src & ~src_q;
  assign wr         = cs & (|we);
  assign wr_pending = wr && (addr[3:2] == REG_PENDING);
  assign wr_mask    = wr && (addr[3:2] == REG_MASK);
  assign wr_eoi     = wr && (addr[3:2] == REG_EOI);

  // Acknowledge is only honoured while a candidate is actually requested;
  // EOI only means something while a source is in service.
  assign take_ack = (state == REQ) && cand_vld && iack;
  assign end_svc  = (state == SERV) && wr_eoi;

  assign w1c_clr = wr_pending ? wdata[N_SRC-1:0] : '0;
  assign ack_clr = take_ack ? (N_SRC'(1) << cand_id) : '0;

  // Priority encoder: lowest enabled pending index wins.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (pending[i] && mask[i]) begin
        cand_vld = 1'b1;
        cand_id  = 3'(i);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next-state logic; candidate loss takes precedence over iack in REQ.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cand_vld) state_nxt = REQ;
      REQ: begin
        if (!cand_vld)  state_nxt = IDLE;
        else if (iack)  state_nxt = SERV;
      end
      SERV: if (wr_eoi) state_nxt = IDLE;
      default:          state_nxt = IDLE;
    endcase
  end

  // FSM outputs: request only in REQ, id follows the live candidate in REQ
  // and holds the latched in-service id in SERV.
  always_comb begin
    irq    = 1'b0;
    irq_id = 3'd0;
    case (state)
      REQ: begin
        irq    = 1'b1;
        irq_id = cand_id;
      end
      SERV:    irq_id = svc_id;
      default: irq_id = 3'd0;
    endcase
  end

  // Source sampling for rising-edge detection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) src_q <= '0;
    else        src_q <= src;
  end

  // Pending bits: clears (W1C, acknowledge) first, new edges override them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pending <= '0;
    else        pending <= (pending & ~(w1c_clr | ack_clr)) | rise;
  end

  // Mask register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       mask <= '0;
    else if (wr_mask) mask <= wdata[N_SRC-1:0];
  end

  // In-service id: captured on acknowledge, cleared when service ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        svc_id <= 3'd0;
    else if (take_ack) svc_id <= cand_id;
    else if (end_svc)  svc_id <= 3'd0;
  end

  // Combinational read mux; zero when deselected, for EOI and unused bits.
  always_comb begin
    rdata = 32'd0;
    if (cs) begin
      case (addr[3:2])
        REG_PENDING: rdata = {{(32-N_SRC){1'b0}}, pending};
        REG_MASK:    rdata = {{(32-N_SRC){1'b0}}, mask};
        REG_STATUS:  rdata = {(state == SERV), 28'd0, svc_id};
        default:     rdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// tb_irq_ctrl: directed scenarios plus randomized traffic for irq_ctrl,
// checked against a behavioural model of the controller's rules.
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src;
  logic        cs;
  logic [3:0]  addr;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;
  logic        iack;
  logic [2:0]  irq_id;

  int checks = 0;
  int errors = 0;

  // Behavioural model state.
  bit [7:0] m_pend;
  bit [7:0] m_mask;
  bit [7:0] m_srcq;
  bit       m_ask;
  bit       m_serv;
  bit [2:0] m_svc;

  irq_ctrl #(.N_SRC(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .src    (src),
    .cs     (cs),
    .addr   (addr),
    .we     (we),
    .wdata  (wdata),
    .rdata  (rdata),
    .irq    (irq),
    .iack   (iack),
    .irq_id (irq_id)
  );

  always #5 clk = ~clk;

  function automatic int first_cand(bit [7:0] p, bit [7:0] m);
    for (int i = 0; i < 8; i++)
      if (p[i] && m[i]) return i;
    return -1;
  endfunction

  function automatic bit [2:0] exp_id();
    int c;
    if (m_ask) begin
      c = first_cand(m_pend, m_mask);
      return (c < 0) ? 3'd0 : 3'(c);
    end
    if (m_serv) return m_svc;
    return 3'd0;
  endfunction

  function automatic bit [31:0] model_rd(bit [3:0] a);
    case (a[3:2])
      2'd0:    return {24'd0, m_pend};
      2'd1:    return {24'd0, m_mask};
      2'd2:    return {m_serv, 28'd0, m_svc};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    m_pend = '0; m_mask = '0; m_srcq = '0;
    m_ask = 1'b0; m_serv = 1'b0; m_svc = '0;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: model advances on the same inputs the DUT sees, then outputs
  // are compared 1 time unit after the edge.
  task automatic tick();
    bit [7:0] rise, np, nm;
    bit       na, ns, wr;
    bit [2:0] nsvc;
    int       c;
    wr   = cs && (we != 4'd0);
    rise = src & ~m_srcq;
    c    = first_cand(m_pend, m_mask);
    np = m_pend; nm = m_mask; na = m_ask; ns = m_serv; nsvc = m_svc;
    if (wr && addr[3:2] == 2'd0) np &= ~wdata[7:0];
    if (wr && addr[3:2] == 2'd1) nm = wdata[7:0];
    if (m_serv) begin
      if (wr && addr[3:2] == 2'd3) begin ns = 1'b0; nsvc = 3'd0; end
    end else if (m_ask) begin
      if (c < 0) na = 1'b0;
      else if (iack) begin
        na = 1'b0; ns = 1'b1; nsvc = 3'(c); np[c] = 1'b0;
      end
    end else if (c >= 0) begin
      na = 1'b1;
    end
    np |= rise;
    @(posedge clk);
    m_pend = np; m_mask = nm; m_ask = na; m_serv = ns; m_svc = nsvc; m_srcq = src;
    #1;
    chk("irq", irq, m_ask);
    chk("irq_id", irq_id, exp_id());
  endtask

  task automatic wr_reg(bit [3:0] a, bit [31:0] d);
    cs = 1'b1; we = 4'hF; addr = a; wdata = d;
    tick();
    cs = 1'b0; we = 4'h0;
  endtask

  task automatic rd(bit [3:0] a, output logic [31:0] d);
    cs = 1'b1; we = 4'h0; addr = a;
    #1;
    d = rdata;
    cs = 1'b0;
  endtask

  task automatic rd_chk(string tag, bit [3:0] a);
    logic [31:0] d;
    rd(a, d);
    chk(tag, d, model_rd(a));
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic reset_mid();
    logic [31:0] d;
    #3;
    src = 8'h00; iack = 1'b0; cs = 1'b0; we = 4'h0;
    reset = 1'b0;
    #1;
    model_clear();
    chk("rst_irq", irq, 1'b0);
    chk("rst_id", irq_id, 3'd0);
    rd(4'h0, d); chk("rst_pend", d, 32'd0);
    rd(4'h4, d); chk("rst_mask", d, 32'd0);
    rd(4'h8, d); chk("rst_status", d, 32'd0);
    @(posedge clk);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b0; src = 8'h00; cs = 1'b0; addr = 4'h0; we = 4'h0;
    wdata = 32'd0; iack = 1'b0;
    model_clear();
    #12;
    chk("por_irq", irq, 1'b0);
    chk("por_id", irq_id, 3'd0);
    rd(4'h8, d); chk("por_status", d, 32'd0);
    #1;
    reset = 1'b1;

    // Single source request / acknowledge / EOI.
    wr_reg(4'h4, 32'h01);
    src = 8'h01; tick();
    rd(4'h0, d); chk("k_pend", d, 32'h01);
    chk("k_irq", irq, 1'b0);
    tick();
    chk("k1_irq", irq, 1'b1);
    chk("k1_id", irq_id, 3'd0);
    tick();
    iack = 1'b1; tick(); iack = 1'b0;
    chk("ack_irq", irq, 1'b0);
    rd(4'h8, d); chk("ack_status", d, 32'h8000_0000);
    rd(4'h0, d); chk("ack_pend", d, 32'h00);
    wr_reg(4'hC, 32'd0);
    rd(4'h8, d); chk("eoi_status", d, 32'd0);

    // Simultaneous edges: priority, then re-raise after EOI.
    src = 8'h00; tick();
    wr_reg(4'h4, 32'hFF);
    src = 8'h24; tick(); tick();
    chk("pri_id", irq_id, 3'd2);
    iack = 1'b1; tick(); iack = 1'b0;
    rd(4'h8, d); chk("pri_status", d, 32'h8000_0002);
    wr_reg(4'hC, 32'd0);
    chk("eoi_low", irq, 1'b0);
    tick();
    chk("rerai_irq", irq, 1'b1);
    chk("rerai_id", irq_id, 3'd5);
    iack = 1'b1; tick(); iack = 1'b0;
    wr_reg(4'hC, 32'd0);
    src = 8'h00; tick();

    // Preemption by a newly enabled higher-priority source.
    reset_mid();
    wr_reg(4'h4, 32'h20);
    src = 8'h20; tick(); tick();
    chk("pre_id5", irq_id, 3'd5);
    src = 8'h22; tick();
    chk("pre_still5", irq_id, 3'd5);
    wr_reg(4'h4, 32'h22);
    chk("pre_irq", irq, 1'b1);
    chk("pre_id1", irq_id, 3'd1);

    // Masking away the request drops irq and leaves pending intact.
    reset_mid();
    wr_reg(4'h4, 32'h08);
    src = 8'h08; tick(); tick();
    chk("msk_id3", irq_id, 3'd3);
    wr_reg(4'h4, 32'h00);
    tick();
    chk("msk_irq", irq, 1'b0);
    rd(4'h0, d); chk("msk_pend", d, 32'h08);

    // Same-edge rise and W1C: set wins; plain W1C clears.
    wr_reg(4'h0, 32'hFF);
    src = 8'h00; tick();
    src = 8'h10;
    wr_reg(4'h0, 32'h10);
    rd(4'h0, d); chk("setwin_pend", d, 32'h10);
    wr_reg(4'h0, 32'h10);
    rd(4'h0, d); chk("w1c_pend", d, 32'h00);

    // Acknowledge coinciding with W1C of the requested bit.
    wr_reg(4'h4, 32'hFF);
    src = 8'h50; tick(); tick();
    chk("ackw1c_id", irq_id, 3'd6);
    cs = 1'b1; we = 4'h1; addr = 4'h0; wdata = 32'h40; iack = 1'b1;
    tick();
    cs = 1'b0; we = 4'h0; iack = 1'b0;
    rd(4'h8, d); chk("ackw1c_status", d, 32'h8000_0006);
    rd(4'h0, d); chk("ackw1c_pend", d, 32'h00);

    // In service: new edge pends, no irq, iack ignored, reads gated.
    src = 8'hD0; tick();
    iack = 1'b1; tick(); iack = 1'b0;
    chk("serv_id", irq_id, 3'd6);
    rd(4'h0, d); chk("serv_pend", d, 32'h80);
    cs = 1'b0; addr = 4'h0; #1; chk("cs0_rdata", rdata, 32'd0);
    rd(4'hC, d); chk("eoi_read", d, 32'd0);

    // Reset mid-service; nothing re-raises without a new edge.
    reset_mid();
    wr_reg(4'h4, 32'hFF);
    tick(); tick(); tick();
    chk("post_rst_irq", irq, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      int op;
      if ($urandom_range(3, 0) == 0) src ^= 8'(1 << $urandom_range(7, 0));
      op = $urandom_range(9, 0);
      if (op < 4) begin
        cs    = 1'b1;
        we    = 4'($urandom_range(15, 1));
        addr  = {2'(op), 2'($urandom_range(3, 0))};
        wdata = $urandom;
      end else begin
        cs = ($urandom_range(1, 0) == 1); we = 4'h0; addr = 4'($urandom);
      end
      iack = ($urandom_range(2, 0) == 0);
      tick();
      iack = 1'b0; we = 4'h0;
      rd_chk("rnd_rdata", 4'($urandom));
      if (i == 300) reset_mid();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
